// File: rtl/trunc_if.sv
// Streaming bus between accumulator drain and trunc_pipe: valid/ready input and output
// beats, runtime shift amount and per-channel saturation flags.
interface trunc_if #(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 8,
  parameter int CH        = 4
);
  localparam int SHIFT_W = $clog2(IN_WIDTH);

  logic [SHIFT_W-1:0]       shift;
  logic                     in_valid;
  logic                     in_ready;
  logic [CH*IN_WIDTH-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH*OUT_WIDTH-1:0]  out_data;
  logic [CH-1:0]            out_sat;

  modport master (
    output shift, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  shift, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/trunc_pipe.sv
// Two-stage multi-channel requantiser: arithmetic right shift (+ round-half-up when
// TRUNC_ROUND_EN is defined), then saturation to OUT_WIDTH with a saturating clip counter.
module trunc_pipe #(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 8,
  parameter int CH        = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  trunc_if.slave           bus,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam int SHIFT_W   = $clog2(IN_WIDTH);
  localparam int MAX_SHIFT = IN_WIDTH - OUT_WIDTH;
  localparam int PW        = $clog2(CH + 1);

  typedef logic signed [IN_WIDTH:0] wide_t;

  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam wide_t WIDE_MAX = wide_t'(OUT_MAX);
  localparam wide_t WIDE_MIN = wide_t'(OUT_MIN);

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] sh);
    return (sh > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : sh;
  endfunction

  // Widened by one bit so the rounding increment cannot overflow the most positive input.
  function automatic wide_t shift_round(input logic signed [IN_WIDTH-1:0] x,
                                        input logic [SHIFT_W-1:0]         s);
    wide_t v;
    v = wide_t'(x);
`ifdef TRUNC_ROUND_EN
    if (s != '0)
      v = v + (wide_t'(1) <<< (s - SHIFT_W'(1)));
`endif
    return v >>> s;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [OUT_WIDTH:0] saturate(input wide_t y);
    if (y > WIDE_MAX)
      return {1'b1, OUT_MAX};
    else if (y < WIDE_MIN)
      return {1'b1, OUT_MIN};
    else
      return {1'b0, y[OUT_WIDTH-1:0]};
  endfunction

  function automatic logic [PW-1:0] popcount(input logic [CH-1:0] f);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < CH; i++)
      n = n + PW'(f[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [PW-1:0]    inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  logic                     vld_p1;
  wide_t                    y_p1 [CH];
  logic                     vld_p2;
  logic [CH*OUT_WIDTH-1:0]  data_p2;
  logic [CH-1:0]            sat_p2;

  logic                     s1_adv;
  logic                     s2_adv;
  logic                     out_hs;
  logic [SHIFT_W-1:0]       s_eff;
  wide_t                    y_nxt [CH];
  logic [CH*OUT_WIDTH-1:0]  data_nxt;
  logic [CH-1:0]            sat_nxt;
  logic [PW-1:0]            beat_clips;

  assign s2_adv = !vld_p2 || bus.out_ready;
  assign s1_adv = !vld_p1 || s2_adv;
  assign out_hs = vld_p2 && bus.out_ready;

  assign bus.in_ready  = s1_adv && !rst;
  assign bus.out_valid = vld_p2;
  assign bus.out_data  = data_p2;
  assign bus.out_sat   = sat_p2;

  assign s_eff      = clamp_shift(bus.shift);
  assign beat_clips = popcount(sat_p2);

  always_comb begin
    for (int c = 0; c < CH; c++)
      y_nxt[c] = shift_round(bus.in_data[c*IN_WIDTH +: IN_WIDTH], s_eff);
  end

  always_comb begin
    data_nxt = '0;
    sat_nxt  = '0;
    for (int c = 0; c < CH; c++)
      {sat_nxt[c], data_nxt[c*OUT_WIDTH +: OUT_WIDTH]} = saturate(y_p1[c]);
  end

  // S1: shifted (and rounded) value, which already embeds the shift sampled with the beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      for (int c = 0; c < CH; c++)
        y_p1[c] <= '0;
    end else if (s1_adv) begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid)
        y_p1 <= y_nxt;
    end
  end

  // S2: saturated output and clip flags, frozen while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      sat_p2  <= '0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= data_nxt;
        sat_p2  <= sat_nxt;
      end
    end
  end

  // Clear wins over accumulation, but a beat leaving in the same cycle still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_cnt <= '0;
    else if (sat_clr)
      sat_cnt <= out_hs ? CNT_W'(beat_clips) : '0;
    else if (out_hs)
      sat_cnt <= sat_add(sat_cnt, beat_clips);
  end

endmodule
